line_buf_ctl: RTL and testbench

//  Previous-line buffer controller for the QUIC pixel path.
//  - Accepts a raster pixel stream.
//  - Drives one single-port synchronous RAM (spram2 instance: registered address, read data valid the cycle after ce).
//  - Emits each pixel together with the pixel directly above it, for the predictor stage.
//  - Per pixel, does a read-before-write at the same RAM address (the column index).

---
 rtl/line_buf_ctl.sv | 173 +++++++++++++++++
 tb/tb_line_buf_ctl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_ctl.sv
// line_buf_ctl -- previous-line buffer controller.
//
// Accepts a raster pixel stream and emits each pixel paired with the pixel
// directly above it. A single-port synchronous RAM holds the previous line.
// The RAM has a registered address, and its read data is valid the cycle
// after ce. For every pixel the controller reads the old word at the column
// address, then writes the new pixel back to that same address.
//
// Optional feature macro: LINE_BUF_ABOVE_LEFT_EN
//   When defined, the module adds output ao_above_left. This output is the
//   pixel above-left of ao_cur, and it is 0 on column 0 and on the first line.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   ai_pix_vld     upstream pixel valid
//   ai_pix         upstream pixel
//   ai_sof         start of frame, qualified by ai_pix_vld
//   ao_pix_rdy     ready to accept a pixel (only in idle)
//   ao_vld         output pair valid
//   ao_cur         current pixel
//   ao_above       pixel above (0 on the first line)
//   ao_eol         ao_cur is the last pixel of its line
//   ai_rdy         downstream ready
//   ao_ram_*       RAM ce/we/oe/address/write data
//   ai_ram_data    RAM read data
//   ao_above_left  (optional) pixel above-left
module line_buf_ctl #(
  parameter int aw     = 10,
  parameter int dw     = 8,
  parameter int LINE_W = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ai_pix_vld,
  input  logic [dw-1:0] ai_pix,
  input  logic          ai_sof,
  output logic          ao_pix_rdy,
  output logic          ao_vld,
  output logic [dw-1:0] ao_cur,
  output logic [dw-1:0] ao_above,
  output logic          ao_eol,
  input  logic          ai_rdy,
`ifdef LINE_BUF_ABOVE_LEFT_EN
  output logic [dw-1:0] ao_above_left,
`endif
  output logic          ao_ram_ce,
  output logic          ao_ram_we,
  output logic          ao_ram_oe,
  output logic [aw-1:0] ao_ram_addr,
  output logic [dw-1:0] ao_ram_data,
  input  logic [dw-1:0] ai_ram_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_OUT} state_t;

  localparam logic [aw-1:0] COL_LAST = aw'(LINE_W - 1);

  state_t        state_q, state_d;
  logic [aw-1:0] col_q, col_d;
  logic          first_q, first_d;
  logic [dw-1:0] cur_q, cur_d;
  logic [dw-1:0] above_q, above_d;
  logic          last_col;

  assign last_col = (col_q == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      first_q <= 1'b1;
      cur_q   <= '0;
      above_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      first_q <= first_d;
      cur_q   <= cur_d;
      above_q <= above_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    first_d     = first_q;
    cur_d       = cur_q;
    above_d     = above_q;
    ao_pix_rdy  = 1'b0;
    ao_vld      = 1'b0;
    ao_ram_ce   = 1'b0;
    ao_ram_we   = 1'b0;
    ao_ram_oe   = 1'b0;
    ao_ram_addr = '0;
    ao_ram_data = '0;
    case (state_q)
      S_IDLE: begin
        ao_pix_rdy = 1'b1;
        if (ai_pix_vld) begin
          cur_d = ai_pix;
          // A start of frame at any column restarts at column 0 of line 0.
          // Any partial line is abandoned.
          if (ai_sof) begin
            col_d   = '0;
            first_d = 1'b1;
          end
          state_d = S_RD;
        end
      end
      S_RD: begin
        ao_ram_ce   = 1'b1;
        ao_ram_addr = col_q;
        state_d     = S_WR;
      end
      S_WR: begin
        // Read data from S_RD is on ai_ram_data now. The write lands at the
        // end of this cycle, so the old word is captured first. On the first
        // line, the RAM holds stale data, so it is masked to 0.
        ao_ram_ce   = 1'b1;
        ao_ram_we   = 1'b1;
        ao_ram_oe   = 1'b1;
        ao_ram_addr = col_q;
        ao_ram_data = cur_q;
        above_d     = first_q ? '0 : ai_ram_data;
        state_d     = S_OUT;
      end
      S_OUT: begin
        ao_vld = 1'b1;
        if (ai_rdy) begin
          state_d = S_IDLE;
          if (last_col) begin
            col_d   = '0;
            first_d = 1'b0;
          end else begin
            col_d = col_q + aw'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ao_cur   = cur_q;
  assign ao_above = above_q;
  assign ao_eol   = (state_q == S_OUT) && last_col;

`ifdef LINE_BUF_ABOVE_LEFT_EN
  logic [dw-1:0] above_left_q, above_left_d;

  // The above-left value is the previous pixel's above value. It is cleared
  // when the next pixel starts a line, because no left neighbour exists.
  // It is also cleared while on the first line.
  always_comb begin
    above_left_d = above_left_q;
    if (state_q == S_IDLE && ai_pix_vld && ai_sof) begin
      above_left_d = '0;
    end else if (state_q == S_OUT && ai_rdy) begin
      above_left_d = (last_col || first_q) ? '0 : above_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      above_left_q <= '0;
    end else begin
      above_left_q <= above_left_d;
    end
  end

  assign ao_above_left = above_left_q;
`endif

endmodule

// File: tb/tb_line_buf_ctl.sv
module tb_line_buf_ctl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ai_pix_vld;
  logic [DW-1:0] ai_pix;
  logic          ai_sof;
  logic          ao_pix_rdy;
  logic          ao_vld;
  logic [DW-1:0] ao_cur;
  logic [DW-1:0] ao_above;
  logic          ao_eol;
  logic          ai_rdy;
`ifdef LINE_BUF_ABOVE_LEFT_EN
  logic [DW-1:0] ao_above_left;
`endif
  logic          ao_ram_ce;
  logic          ao_ram_we;
  logic          ao_ram_oe;
  logic [AW-1:0] ao_ram_addr;
  logic [DW-1:0] ao_ram_data;
  logic [DW-1:0] ai_ram_data;

  always #5 clk = ~clk;

  line_buf_ctl #(.aw(AW), .dw(DW), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ai_pix_vld   (ai_pix_vld),
    .ai_pix       (ai_pix),
    .ai_sof       (ai_sof),
    .ao_pix_rdy   (ao_pix_rdy),
    .ao_vld       (ao_vld),
    .ao_cur       (ao_cur),
    .ao_above     (ao_above),
    .ao_eol       (ao_eol),
    .ai_rdy       (ai_rdy),
`ifdef LINE_BUF_ABOVE_LEFT_EN
    .ao_above_left(ao_above_left),
`endif
    .ao_ram_ce    (ao_ram_ce),
    .ao_ram_we    (ao_ram_we),
    .ao_ram_oe    (ao_ram_oe),
    .ao_ram_addr  (ao_ram_addr),
    .ao_ram_data  (ao_ram_data),
    .ai_ram_data  (ai_ram_data)
  );

  // Single-port RAM: registered read, so data appears the cycle after ce.
  // Its contents start as random garbage.
  logic          ram_init;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ram_q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= DW'($urandom);
    end else if (ao_ram_ce) begin
      if (ao_ram_we) mem[ao_ram_addr] <= ao_ram_data;
      else           ram_q <= mem[ao_ram_addr];
    end
  end
  assign ai_ram_data = ram_q;

  // Reference model: the column position and a copy of the previous line.
  int            n_tests = 0;
  int            n_fail  = 0;
  int            col_m;
  bit            first_m;
  logic [DW-1:0] prev_m [LW];
  logic [DW-1:0] last_above_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] p, input bit s, input int hold, input bit rst_in_wr);
    int            n;
    logic [DW-1:0] ea;
    logic [DW-1:0] eal;
    bit            ee;
    n = 0;
    while (ao_pix_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_rdy", ao_pix_rdy, 1);
    if (s) begin
      col_m   = 0;
      first_m = 1;
    end
    ea  = first_m ? '0 : prev_m[col_m];
    ee  = (col_m == LW - 1);
    eal = (col_m == 0 || first_m) ? '0 : last_above_m;
    ai_pix_vld = 1'b1;
    ai_pix     = p;
    ai_sof     = s;
    ai_rdy     = 1'($urandom);
    @(negedge clk);
    // S_RD; busy-state inputs are random garbage that must be ignored.
    ai_pix_vld = 1'($urandom);
    ai_sof     = 1'($urandom);
    ai_pix     = DW'($urandom);
    ai_rdy     = 1'($urandom);
    check("rd_ce", ao_ram_ce, 1);
    check("rd_we", ao_ram_we, 0);
    check("rd_oe", ao_ram_oe, 0);
    check("rd_addr", ao_ram_addr, col_m);
    check("rd_pix_rdy", ao_pix_rdy, 0);
    check("rd_vld", ao_vld, 0);
    @(negedge clk);
    // S_WR
    ai_rdy = 1'b0;
    check("wr_ce", ao_ram_ce, 1);
    check("wr_we", ao_ram_we, 1);
    check("wr_oe", ao_ram_oe, 1);
    check("wr_addr", ao_ram_addr, col_m);
    check("wr_data", ao_ram_data, p);
    check("wr_vld", ao_vld, 0);
    prev_m[col_m] = p;
    if (rst_in_wr) begin
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      ai_pix_vld = 1'b0;
      ai_sof     = 1'b0;
      check("rst_vld", ao_vld, 0);
      check("rst_pix_rdy", ao_pix_rdy, 1);
      check("rst_ce", ao_ram_ce, 0);
      col_m        = 0;
      first_m      = 1;
      last_above_m = '0;
      $display("[TB] pix=%0d sof=%0d dropped by reset in S_WR", p, s);
      return;
    end
    @(negedge clk);
    // S_OUT: three cycles after the accept edge.
    check("out_vld", ao_vld, 1);
    check("out_cur", ao_cur, p);
    check("out_above", ao_above, ea);
    check("out_eol", ao_eol, ee);
    check("out_ce", ao_ram_ce, 0);
    check("out_pix_rdy", ao_pix_rdy, 0);
`ifdef LINE_BUF_ABOVE_LEFT_EN
    check("out_above_left", ao_above_left, eal);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      ai_pix_vld = 1'($urandom);
      ai_sof     = 1'($urandom);
      check("bp_vld", ao_vld, 1);
      check("bp_cur", ao_cur, p);
      check("bp_above", ao_above, ea);
      check("bp_eol", ao_eol, ee);
      check("bp_pix_rdy", ao_pix_rdy, 0);
      check("bp_ce", ao_ram_ce, 0);
    end
    ai_rdy     = 1'b1;
    ai_pix_vld = 1'b0;
    ai_sof     = 1'b0;
    @(negedge clk);
    ai_rdy = 1'b0;
    check("post_vld", ao_vld, 0);
    check("post_pix_rdy", ao_pix_rdy, 1);
    check("post_ce", ao_ram_ce, 0);
    $display("[TB] pix=%0d sof=%0d col=%0d above=%0d eol=%0d al=%0d hold=%0d", p, s, col_m, ea, ee, eal, hold);
    last_above_m = ea;
    if (col_m == LW - 1) begin
      col_m   = 0;
      first_m = 0;
    end else begin
      col_m++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    ram_init     = 1'b1;
    ai_pix_vld   = 1'b0;
    ai_pix       = '0;
    ai_sof       = 1'b0;
    ai_rdy       = 1'b0;
    col_m        = 0;
    first_m      = 1;
    last_above_m = '0;
    for (int i = 0; i < LW; i++) prev_m[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_vld", ao_vld, 0);
    check("reset_pix_rdy", ao_pix_rdy, 1);
    check("reset_ce", ao_ram_ce, 0);
    check("reset_we", ao_ram_we, 0);
    check("reset_addr", ao_ram_addr, 0);
    check("reset_cur", ao_cur, 0);
    check("reset_above", ao_above, 0);
    check("reset_eol", ao_eol, 0);
    rst      = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);

    // Three lines of sequential pixels, starting with a start of frame.
    for (int v = 1; v <= 12; v++) send(DW'(v), v == 1, 0, 0);
    // Backpressure on line 3, column 0.
    send(DW'(13), 0, 5, 0);
    // Frame restart mid-line.
    send(DW'(14), 0, 0, 0);
    send(DW'(15), 1, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      send(DW'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 0);
    end

    // Reset during S_WR, then two clean lines.
    send(DW'(100), 1, 0, 0);
    send(DW'(101), 0, 0, 0);
    send(DW'(102), 0, 0, 1);
    for (int v = 1; v <= 8; v++) send(DW'(v), 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
